// File: rtl/counter_mod_n_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
package counter_pkg;

  localparam int COUNTER_MAX_N = 65536;

  // max(1, ceil(log2(n))), evaluated at elaboration only.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter_mod_n.sv
// Free-running modulo-N up-counter: count index, terminal-count decode and
// a registered wrap pulse for downstream phase logic.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter  int N     = 16,
  localparam int WIDTH = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(N - 1);

  generate
    if (N < 2 || N > COUNTER_MAX_N) begin : g_bad_n
      $fatal(1, "counter_mod_n: N=%0d outside legal range 2..%0d", N, COUNTER_MAX_N);
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             is_max;

  assign is_max  = (count_q == MAX_V);
  // >= also flushes any out-of-range value (e.g. upset bit) back to 0.
  assign count_d = (count_q >= MAX_V) ? '0 : count_q + 1'b1;
  assign wrap_d  = is_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count  = count_q;
  assign at_max = is_max;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_counter_mod_n.sv
// Bench for counter_mod_n at N=16, 10 and 2 sharing one clock and reset.
module tb_counter_mod_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] c16, c10;
  logic [0:0] c2;
  logic       m16, m10, m2;
  logic       w16, w10, w2;

  always #5 clk = ~clk;

  counter_mod_n #(.N(16)) u16 (.clk(clk), .rst_n(rst_n), .count(c16), .at_max(m16), .wrap(w16));
  counter_mod_n #(.N(10)) u10 (.clk(clk), .rst_n(rst_n), .count(c10), .at_max(m10), .wrap(w10));
  counter_mod_n #(.N(2))  u2  (.clk(clk), .rst_n(rst_n), .count(c2),  .at_max(m2),  .wrap(w2));

  int n_chk  = 0;
  int n_pass = 0;
  // Reference: number of rising edges seen with reset released.
  int k = 0;

  typedef struct {
    bit rst;
    int cnt;
    bit mx;
    bit wr;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", name, got, exp, k, $time);
  endtask

  task automatic chk_n(input string tag, input int n, input int cnt, input bit mx, input bit wr);
    int e;
    e = rst_n ? (k % n) : 0;
    chk({tag, ".count"}, cnt, e);
    chk({tag, ".at_max"}, int'(mx), int'(e == n - 1));
    chk({tag, ".wrap"}, int'(wr), int'(rst_n && k > 0 && (k % n) == 0));
  endtask

  task automatic check_all();
    chk_n("n16", 16, int'(c16), m16, w16);
    chk_n("n10", 10, int'(c10), m10, w10);
    chk_n("n2",  2,  int'(c2),  m2,  w2);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) k++;
    @(negedge clk);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_all();
    end
  endtask

  // Asynchronous assertion mid-cycle, checked before the next rising edge.
  task automatic mid_reset(input int hold);
    #2 rst_n = 1'b0;
    k = 0;
    #1 check_all();
    for (int i = 0; i < hold; i++) begin
      tick();
      check_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    tbl = '{
      '{1'b0, 0, 1'b0, 1'b0}, '{1'b0, 0, 1'b0, 1'b0},
      '{1'b1, 1, 1'b0, 1'b0}, '{1'b1, 2, 1'b0, 1'b0}, '{1'b1, 3, 1'b0, 1'b0},
      '{1'b1, 4, 1'b0, 1'b0}, '{1'b1, 5, 1'b0, 1'b0}, '{1'b1, 6, 1'b0, 1'b0},
      '{1'b1, 7, 1'b0, 1'b0}, '{1'b1, 8, 1'b0, 1'b0}, '{1'b1, 9, 1'b0, 1'b0},
      '{1'b1, 10, 1'b0, 1'b0}, '{1'b1, 11, 1'b0, 1'b0}, '{1'b1, 12, 1'b0, 1'b0},
      '{1'b1, 13, 1'b0, 1'b0}, '{1'b1, 14, 1'b0, 1'b0}, '{1'b1, 15, 1'b1, 1'b0},
      '{1'b1, 0, 1'b0, 1'b1}, '{1'b1, 1, 1'b0, 1'b0}
    };

    // Power-on reset: outputs must already be cleared before any edge.
    #1 check_all();
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      rst_n = tbl[i].rst;
      if (!rst_n) k = 0;
      tick();
      chk("tbl.count",  int'(c16), tbl[i].cnt);
      chk("tbl.at_max", int'(m16), int'(tbl[i].mx));
      chk("tbl.wrap",   int'(w16), int'(tbl[i].wr));
    end

    // Full wrap window plus N=10 / N=2 sequences.
    run(30);

    // Mid-run reset at a count of about 4 on the N=16 counter.
    while (c16 != 4'd4) tick();
    mid_reset(2);
    check_all();
    run(20);

    // Randomized runs with random asynchronous reset pulses.
    for (int it = 0; it < 40; it++) begin
      run(int'($urandom_range(1, 40)));
      if ($urandom_range(0, 9) < 3) begin
        mid_reset(int'($urandom_range(1, 3)));
        check_all();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
